// File: rtl/wb8_timeout_guard.sv
// wb8_timeout_guard: wishbone8 pass-through that aborts strobes left un-acked for TIMEOUT cycles and logs each abort
// Build option: define WB8_TIMEOUT_IRQ_EN to enable STATUS.irq_en and the O_irq output.
// Ports: I_wb_clk/I_reset_n clock and async active-low reset;
//   I_m_* / O_m_* master side, O_s_* / I_s_* arbiter side (combinational pass-through);
//   I_reg_* / O_reg_* register slave port (0 STATUS, 1 COUNT, 4-7 ADDR bytes); O_irq timeout interrupt.
module wb8_timeout_guard #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNTBITS = 16,
  parameter logic [7:0]  ERRDATA = 8'hFF
) (
  input  logic        I_wb_clk,
  input  logic        I_reset_n,
  input  logic        I_m_stb,
  input  logic        I_m_we,
  input  logic [31:0] I_m_adr,
  input  logic [7:0]  I_m_dat,
  output logic [7:0]  O_m_dat,
  output logic        O_m_ack,
  output logic        O_m_stall,
  output logic        O_s_stb,
  output logic        O_s_we,
  output logic [31:0] O_s_adr,
  output logic [7:0]  O_s_dat,
  input  logic [7:0]  I_s_dat,
  input  logic        I_s_ack,
  input  logic        I_s_stall,
  input  logic        I_reg_stb,
  input  logic        I_reg_we,
  input  logic [2:0]  I_reg_adr,
  input  logic [7:0]  I_reg_dat,
  output logic [7:0]  O_reg_dat,
  output logic        O_reg_ack,
  output logic        O_irq
);
`ifdef WB8_TIMEOUT_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif
  localparam logic [CNTBITS-1:0] LAST = CNTBITS'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, WAIT, ABORT} state_t;
  state_t state_q, state_d;
  logic [CNTBITS-1:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0] count_q, count_d, reg_dat_q, reg_dat_d, rd;
  logic flag_q, flag_d, irq_en_q, irq_en_d, irq_q, irq_d, reg_ack_q, reg_ack_d;
  logic abort, acc, wr;
  assign abort = state_q == ABORT;
  // the counter holds the number of cycles the current transfer has already been waiting
  always_comb begin
    state_d = state_q;
    cnt_d = '0;
    if (state_q == IDLE) begin
      if (I_m_stb & ~I_s_ack) begin
        state_d = WAIT;
        cnt_d = CNTBITS'(1);
      end
    end else if (state_q == WAIT) begin
      if (I_s_ack) state_d = I_m_stb ? WAIT : IDLE;
      else if (cnt_q == LAST) state_d = ABORT;
      else cnt_d = cnt_q + CNTBITS'(1);
    end else begin
      state_d = IDLE;
    end
  end
  // a register access is taken once per strobe; the cycle it is acked does not count again
  assign acc = I_reg_stb & ~reg_ack_q;
  assign wr = acc & I_reg_we;
  always_comb begin
    rd = I_reg_adr == 3'd0 ? {6'b0, irq_en_q, flag_q} :
         I_reg_adr == 3'd1 ? count_q :
         I_reg_adr[2] ? addr_q[{I_reg_adr[1:0], 3'b000} +: 8] : 8'h00;
    flag_d = abort | (flag_q & ~(wr & I_reg_adr == 3'd0 & I_reg_dat[0]));
    irq_en_d = IRQ & ((wr & I_reg_adr == 3'd0) ? I_reg_dat[1] : irq_en_q);
    count_d = abort ? (count_q == 8'hFF ? count_q : count_q + 8'd1) :
              (wr & I_reg_adr == 3'd1) ? 8'h00 : count_q;
    addr_d = abort ? I_m_adr : addr_q;
    irq_d = flag_d & irq_en_d;
    reg_ack_d = acc;
    reg_dat_d = acc ? rd : reg_dat_q;
  end
  always_ff @(posedge I_wb_clk or negedge I_reset_n)
    if (!I_reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      flag_q <= 1'b0;
      irq_en_q <= 1'b0;
      irq_q <= 1'b0;
      count_q <= 8'h00;
      addr_q <= 32'h0;
      reg_ack_q <= 1'b0;
      reg_dat_q <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      flag_q <= flag_d;
      irq_en_q <= irq_en_d;
      irq_q <= irq_d;
      count_q <= count_d;
      addr_q <= addr_d;
      reg_ack_q <= reg_ack_d;
      reg_dat_q <= reg_dat_d;
    end
  // master-facing controls are forced low while reset is held so an in-flight transfer drops at once
  assign O_s_stb = I_reset_n & ~abort & I_m_stb;
  assign O_s_we = I_m_we;
  assign O_s_adr = I_m_adr;
  assign O_s_dat = I_m_dat;
  assign O_m_ack = I_reset_n & (abort | I_s_ack);
  assign O_m_stall = I_reset_n & ~abort & I_s_stall;
  assign O_m_dat = abort ? ERRDATA : I_s_dat;
  assign O_reg_ack = reg_ack_q;
  assign O_reg_dat = reg_dat_q;
  assign O_irq = irq_q;
endmodule

// File: tb/tb_wb8_timeout_guard.sv
// tb_wb8_timeout_guard: directed self-checking bench for wb8_timeout_guard with TIMEOUT=16
module tb_wb8_timeout_guard;
`ifdef WB8_TIMEOUT_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif
  logic I_wb_clk = 1'b0, I_reset_n;
  logic I_m_stb, I_m_we, I_s_ack, I_s_stall, I_reg_stb, I_reg_we;
  logic [31:0] I_m_adr;
  logic [7:0] I_m_dat, I_s_dat, I_reg_dat;
  logic [2:0] I_reg_adr;
  logic [7:0] O_m_dat, O_s_dat, O_reg_dat;
  logic [31:0] O_s_adr;
  logic O_m_ack, O_m_stall, O_s_stb, O_s_we, O_reg_ack, O_irq;
  int total = 0, bad = 0;
  logic [7:0] d;
  int cyc, early, nb;
  always #5 I_wb_clk = ~I_wb_clk;
  wb8_timeout_guard #(.TIMEOUT(16)) dut (
    .I_wb_clk(I_wb_clk), .I_reset_n(I_reset_n),
    .I_m_stb(I_m_stb), .I_m_we(I_m_we), .I_m_adr(I_m_adr), .I_m_dat(I_m_dat),
    .O_m_dat(O_m_dat), .O_m_ack(O_m_ack), .O_m_stall(O_m_stall),
    .O_s_stb(O_s_stb), .O_s_we(O_s_we), .O_s_adr(O_s_adr), .O_s_dat(O_s_dat),
    .I_s_dat(I_s_dat), .I_s_ack(I_s_ack), .I_s_stall(I_s_stall),
    .I_reg_stb(I_reg_stb), .I_reg_we(I_reg_we), .I_reg_adr(I_reg_adr), .I_reg_dat(I_reg_dat),
    .O_reg_dat(O_reg_dat), .O_reg_ack(O_reg_ack), .O_irq(O_irq)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge I_wb_clk);
    #2;
  endtask
  task automatic reg_rd(input logic [2:0] a, output logic [7:0] v);
    I_reg_stb = 1'b1; I_reg_we = 1'b0; I_reg_adr = a;
    tick;
    chk("reg_rd_ack", O_reg_ack, 1);
    v = O_reg_dat;
    I_reg_stb = 1'b0;
    tick;
  endtask
  task automatic reg_wr(input logic [2:0] a, input logic [7:0] v);
    I_reg_stb = 1'b1; I_reg_we = 1'b1; I_reg_adr = a; I_reg_dat = v;
    tick;
    chk("reg_wr_ack", O_reg_ack, 1);
    I_reg_stb = 1'b0; I_reg_we = 1'b0;
    tick;
  endtask
  // holds a strobe with no device ack; cyc is the 0-based cycle of the abort ack, -1 if none
  task automatic do_abort(input logic [31:0] a, output int c);
    c = -1;
    I_m_stb = 1'b1; I_m_we = 1'b0; I_m_adr = a; I_s_ack = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (O_m_ack) begin
        c = i;
        break;
      end
      tick;
    end
  endtask
  initial begin
    I_reset_n = 1'b0;
    I_m_stb = 1'b1; I_m_we = 1'b0; I_m_adr = 32'h0; I_m_dat = 8'h00;
    I_s_dat = 8'h00; I_s_ack = 1'b1; I_s_stall = 1'b1;
    I_reg_stb = 1'b0; I_reg_we = 1'b0; I_reg_adr = 3'd0; I_reg_dat = 8'h00;
    #3;
    chk("rst_s_stb", O_s_stb, 0);
    chk("rst_m_ack", O_m_ack, 0);
    chk("rst_m_stall", O_m_stall, 0);
    chk("rst_reg_ack", O_reg_ack, 0);
    chk("rst_reg_dat", O_reg_dat, 0);
    chk("rst_irq", O_irq, 0);
    I_m_stb = 1'b0; I_s_ack = 1'b0; I_s_stall = 1'b0;
    tick;
    I_reset_n = 1'b1;
    tick;
    // read of 0x100, device stalls one cycle and acks in cycle 3
    I_m_stb = 1'b1; I_m_we = 1'b0; I_m_adr = 32'h100; I_m_dat = 8'h77; I_s_stall = 1'b1;
    #1;
    chk("pt_s_stb", O_s_stb, 1);
    chk("pt_s_adr", O_s_adr, 32'h100);
    chk("pt_s_dat", O_s_dat, 8'h77);
    chk("pt_m_stall", O_m_stall, 1);
    tick;
    I_s_stall = 1'b0;
    tick;
    tick;
    I_s_ack = 1'b1; I_s_dat = 8'h5A;
    #1;
    chk("pt_m_ack", O_m_ack, 1);
    chk("pt_m_dat", O_m_dat, 8'h5A);
    I_m_stb = 1'b0;
    tick;
    I_s_ack = 1'b0;
    #1;
    chk("pt_ack_done", O_m_ack, 0);
    reg_rd(3'd1, d); chk("pt_count", d, 8'h00);
    reg_rd(3'd0, d); chk("pt_status", d, 8'h00);
    chk("reg_ack_pulse", O_reg_ack, 0);
    // no ack for 0xFFFFFB00: abort on cycle 16 counted from the strobe cycle
    do_abort(32'hFFFFFB00, cyc);
    chk("to_cycle", cyc, 16);
    chk("to_m_dat", O_m_dat, 8'hFF);
    chk("to_s_stb", O_s_stb, 0);
    chk("to_m_stall", O_m_stall, 0);
    I_m_stb = 1'b0;
    tick;
    #1;
    chk("to_one_cycle", O_m_ack, 0);
    reg_rd(3'd0, d); chk("to_status", d, 8'h01);
    reg_rd(3'd1, d); chk("to_count", d, 8'h01);
    reg_rd(3'd4, d); chk("to_addr0", d, 8'h00);
    reg_rd(3'd5, d); chk("to_addr1", d, 8'hFB);
    reg_rd(3'd6, d); chk("to_addr2", d, 8'hFF);
    reg_rd(3'd7, d); chk("to_addr3", d, 8'hFF);
    reg_wr(3'd2, 8'hAA);
    reg_rd(3'd2, d); chk("reg2_zero", d, 8'h00);
    reg_wr(3'd0, 8'h01);
    reg_rd(3'd0, d); chk("flag_clear", d, 8'h00);
    // device acks in the last allowed cycle (counter at TIMEOUT-1): device wins
    I_m_stb = 1'b1; I_m_adr = 32'h200; early = 0;
    for (int i = 0; i < 15; i++) begin
      #1;
      if (O_m_ack) early++;
      tick;
    end
    chk("edge_no_early_ack", early, 0);
    I_s_ack = 1'b1; I_s_dat = 8'h3C;
    #1;
    chk("edge_m_ack", O_m_ack, 1);
    chk("edge_m_dat", O_m_dat, 8'h3C);
    I_m_stb = 1'b0;
    tick;
    I_s_ack = 1'b0;
    #1;
    chk("edge_no_abort", O_m_ack, 0);
    reg_rd(3'd0, d); chk("edge_status", d, 8'h00);
    reg_rd(3'd1, d); chk("edge_count", d, 8'h01);
    // interrupt enable, abort, then clear flag while keeping irq_en
    reg_wr(3'd0, 8'h02);
    reg_rd(3'd0, d); chk("irq_en_rd", d, IRQ ? 8'h02 : 8'h00);
    do_abort(32'hABCD0000, cyc);
    chk("irq_to_cycle", cyc, 16);
    chk("irq_not_yet", O_irq, 0);
    I_m_stb = 1'b0;
    tick;
    chk("irq_set", O_irq, IRQ);
    reg_wr(3'd0, 8'h03);
    chk("irq_clr", O_irq, 0);
    reg_rd(3'd0, d); chk("irq_status", d, IRQ ? 8'h02 : 8'h00);
    reg_rd(3'd1, d); chk("irq_count", d, 8'h02);
    // 300 aborts saturate COUNT; the last one collides with a flag-clear write
    nb = 0;
    for (int k = 0; k < 300; k++) begin
      do_abort(32'h1234 + k, cyc);
      if (cyc != 16) nb++;
      I_m_stb = 1'b0;
      if (k == 299) begin
        I_reg_stb = 1'b1; I_reg_we = 1'b1; I_reg_adr = 3'd0; I_reg_dat = 8'h01;
      end
      tick;
      I_reg_stb = 1'b0; I_reg_we = 1'b0;
      tick;
    end
    chk("sat_abort_cycles", nb, 0);
    reg_rd(3'd1, d); chk("sat_count", d, 8'hFF);
    reg_rd(3'd0, d); chk("set_wins", d, 8'h01);
    reg_rd(3'd4, d); chk("sat_addr0", d, 8'h5F);
    reg_rd(3'd5, d); chk("sat_addr1", d, 8'h13);
    chk("sat_irq", O_irq, 0);
    reg_wr(3'd1, 8'h00);
    reg_rd(3'd1, d); chk("count_clr", d, 8'h00);
    do_abort(32'h4000, cyc);
    I_m_stb = 1'b0;
    tick;
    tick;
    // reset while waiting at counter 10
    I_m_stb = 1'b1; I_m_adr = 32'h300;
    for (int i = 0; i < 10; i++) tick;
    I_reset_n = 1'b0;
    #1;
    chk("mid_rst_s_stb", O_s_stb, 0);
    chk("mid_rst_m_ack", O_m_ack, 0);
    tick;
    tick;
    I_m_stb = 1'b0;
    I_reset_n = 1'b1;
    tick;
    reg_rd(3'd1, d); chk("mid_rst_count", d, 8'h00);
    reg_rd(3'd0, d); chk("mid_rst_status", d, 8'h00);
    do_abort(32'h500, cyc);
    chk("mid_rst_idle", cyc, 16);
    I_m_stb = 1'b0;
    tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
